// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the byte-serial memory controller.
// Holds controller states, data width codes and the length decode.
package mem_ctrl_pkg;

    typedef enum logic [2:0] {
        MEM_IDLE,
        MEM_IREAD,
        MEM_DREAD,
        MEM_DWRITE,
        MEM_DONE
    } mem_state_e;

    localparam logic [1:0] MEM_W_BYTE = 2'd0;
    localparam logic [1:0] MEM_W_HALF = 2'd1;
    localparam logic [1:0] MEM_W_WORD = 2'd2;

    // Index of the final byte of a data transfer; code 3 behaves as a word.
    function automatic logic [1:0] data_last(input logic [1:0] width);
        case (width)
            MEM_W_BYTE: data_last = 2'd0;
            MEM_W_HALF: data_last = 2'd1;
            MEM_W_WORD: data_last = 2'd3;
            default:    data_last = 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial controller sharing one 8-bit synchronous RAM between
// instruction line refills and 1/2/4-byte data loads and stores.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W     = 17,
    parameter int LINE_BYTES = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rdy,
    input  logic                    inst_re,
    input  logic [31:0]             inst_addr,
    output logic [8*LINE_BYTES-1:0] inst_data,
    output logic                    inst_busy,
    input  logic                    data_re,
    input  logic                    data_we,
    input  logic [31:0]             data_addr,
    input  logic [1:0]              data_width,
    input  logic [31:0]             data_wdata,
    output logic [31:0]             data_rdata,
    output logic                    data_busy,
    input  logic [7:0]              mem_din,
    output logic [7:0]              mem_dout,
    output logic [ADDR_W-1:0]       mem_a,
    output logic                    mem_wr
);

    localparam int CW = $clog2(LINE_BYTES);

    mem_state_e        state;
    mem_state_e        state_n;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     cnt_nx;
    logic [CW-1:0]     last_idx;
    logic              is_last;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] next_a;
    logic [ADDR_W-1:0] line_base;
    logic [31:0]       wdata_q;
    logic [1:0]        width_q;
    logic              wr_q;
    logic              unused_addr;

    assign line_base = {inst_addr[ADDR_W-1:CW], {CW{1'b0}}};
    assign cnt_nx    = cnt + CW'(1);
    assign next_a    = base + ADDR_W'(cnt_nx);
    assign last_idx  = (state == MEM_IREAD) ? CW'(LINE_BYTES - 1)
                                            : CW'(data_last(width_q));
    assign is_last   = (cnt == last_idx);

    // A frozen write cycle must not strobe the RAM.
    assign mem_wr = wr_q & rdy;

    assign unused_addr = ^{inst_addr[31:ADDR_W], inst_addr[CW-1:0],
                           data_addr[31:ADDR_W]};

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= MEM_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state: data beats instruction, DONE absorbs the lingering request.
    always_comb begin
        state_n = state;
        if (rdy) begin
            unique case (state)
                MEM_IDLE: begin
                    if (data_we) begin
                        state_n = MEM_DWRITE;
                    end else if (data_re) begin
                        state_n = MEM_DREAD;
                    end else if (inst_re) begin
                        state_n = MEM_IREAD;
                    end
                end
                MEM_IREAD, MEM_DREAD, MEM_DWRITE: begin
                    if (is_last) begin
                        state_n = MEM_DONE;
                    end
                end
                MEM_DONE: state_n = MEM_IDLE;
                default:  state_n = MEM_IDLE;
            endcase
        end
    end

    // Datapath: latch request, step the RAM address, assemble or emit bytes.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            base       <= '0;
            wdata_q    <= '0;
            width_q    <= MEM_W_BYTE;
            wr_q       <= 1'b0;
            inst_busy  <= 1'b0;
            data_busy  <= 1'b0;
            inst_data  <= '0;
            data_rdata <= '0;
            mem_a      <= '0;
            mem_dout   <= '0;
        end else if (rdy) begin
            unique case (state)
                MEM_IDLE: begin
                    cnt <= '0;
                    if (data_we || data_re) begin
                        base      <= data_addr[ADDR_W-1:0];
                        mem_a     <= data_addr[ADDR_W-1:0];
                        width_q   <= data_width;
                        wdata_q   <= data_wdata;
                        data_busy <= 1'b1;
                        if (data_we) begin
                            wr_q     <= 1'b1;
                            mem_dout <= data_wdata[7:0];
                        end
                    end else if (inst_re) begin
                        base      <= line_base;
                        mem_a     <= line_base;
                        inst_busy <= 1'b1;
                    end
                end
                MEM_IREAD: begin
                    inst_data[{cnt, 3'b000} +: 8] <= mem_din;
                    if (is_last) begin
                        inst_busy <= 1'b0;
                    end else begin
                        cnt   <= cnt_nx;
                        mem_a <= next_a;
                    end
                end
                MEM_DREAD: begin
                    if (cnt == '0) begin
                        data_rdata <= {24'd0, mem_din};
                    end else begin
                        data_rdata[{cnt[1:0], 3'b000} +: 8] <= mem_din;
                    end
                    if (is_last) begin
                        data_busy <= 1'b0;
                    end else begin
                        cnt   <= cnt_nx;
                        mem_a <= next_a;
                    end
                end
                MEM_DWRITE: begin
                    if (is_last) begin
                        wr_q      <= 1'b0;
                        data_busy <= 1'b0;
                    end else begin
                        cnt      <= cnt_nx;
                        mem_a    <= next_a;
                        mem_dout <= wdata_q[{cnt_nx[1:0], 3'b000} +: 8];
                    end
                end
                MEM_DONE: cnt <= '0;
                default:  cnt <= '0;
            endcase
        end
    end

endmodule
